// File: rtl/logic_bist_checker.sv
// Exhaustive vector walker: drives every input pattern to a small combinational DUT and
// checks its single-bit response against EXP_TT, reporting a mismatch count and the first failing vector.
module logic_bist_checker #(
   parameter int unsigned N_IN = 2,
   parameter logic [(2**N_IN)-1:0] EXP_TT = 4'b1000,
   parameter int unsigned SETTLE = 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   output logic [N_IN-1:0] o_stim,
   input  logic            i_resp,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_pass,
   output logic [N_IN:0]   o_fail_cnt,
   output logic [N_IN-1:0] o_first_fail_vec
);

   localparam int unsigned SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
   localparam logic [SW-1:0]   SETTLE_C = SW'(SETTLE);
   localparam logic [SW-1:0]   SET_ONE  = SW'(1);
   localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};
   localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
   localparam logic [N_IN:0]   CNT_ONE  = (N_IN + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [N_IN-1:0] stim_q, stim_d;
   logic [SW-1:0]   settle_q, settle_d;
   logic [N_IN:0]   fail_cnt_q, fail_cnt_d;
   logic [N_IN-1:0] first_fail_q, first_fail_d;
   logic            mismatch;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= S_IDLE;
         stim_q       <= '0;
         settle_q     <= '0;
         fail_cnt_q   <= '0;
         first_fail_q <= '0;
      end else begin
         state_q      <= state_d;
         stim_q       <= stim_d;
         settle_q     <= settle_d;
         fail_cnt_q   <= fail_cnt_d;
         first_fail_q <= first_fail_d;
      end
   end

   assign mismatch = (i_resp != EXP_TT[stim_q]);

   always_comb begin
      state_d      = state_q;
      stim_d       = stim_q;
      settle_d     = settle_q;
      fail_cnt_d   = fail_cnt_q;
      first_fail_d = first_fail_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            // A start from DONE clears results on the same edge the new run begins.
            if (S_IDLE == state_q) begin
               stim_d = '0;
            end
            if (i_start) begin
               state_d      = S_DRIVE;
               stim_d       = '0;
               settle_d     = SET_ONE;
               fail_cnt_d   = '0;
               first_fail_d = '0;
            end
         end
         S_DRIVE: begin
            if (settle_q == SETTLE_C) begin
               state_d = S_SAMPLE;
            end else begin
               settle_d = settle_q + SET_ONE;
            end
         end
         S_SAMPLE: begin
            if (mismatch) begin
               fail_cnt_d = fail_cnt_q + CNT_ONE;
               if (fail_cnt_q == '0) begin
                  first_fail_d = stim_q;
               end
            end
            // The last vector is held; the run ends without wrapping o_stim.
            if (stim_q == LAST_VEC) begin
               state_d = S_DONE;
            end else begin
               state_d  = S_DRIVE;
               stim_d   = stim_q + VEC_ONE;
               settle_d = SET_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign o_stim           = stim_q;
   assign o_busy           = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
   assign o_done           = (state_q == S_DONE);
   assign o_pass           = o_done && (fail_cnt_q == '0);
   assign o_fail_cnt       = fail_cnt_q;
   assign o_first_fail_vec = first_fail_q;

endmodule

// File: tb/tb_logic_bist_checker.sv
// Bench for logic_bist_checker with default parameters (2-input AND truth table).
// The driver queues expected stimulus and results; a monitor checks them as the DUT presents them.
module tb_logic_bist_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] stim;
   logic       resp;
   logic       busy;
   logic       done;
   logic       pass;
   logic [2:0] fail_cnt;
   logic [1:0] first_fail;

   int         resp_mode;   // 0 AND, 1 tied 0, 2 OR, 3 NAND
   bit         mon_en;
   int         n_checks;
   int         n_pass;

   typedef struct {
      int fail;
      int first;
      int pass;
      int lat;
   } res_t;

   int   exp_stim_q[$];
   res_t exp_res_q[$];

   logic_bist_checker dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_start          (start),
      .o_stim           (stim),
      .i_resp           (resp),
      .o_busy           (busy),
      .o_done           (done),
      .o_pass           (pass),
      .o_fail_cnt       (fail_cnt),
      .o_first_fail_vec (first_fail)
   );

   always #5 clk = ~clk;

   always_comb begin
      case (resp_mode)
         0:       resp = &stim;
         1:       resp = 1'b0;
         2:       resp = |stim;
         default: resp = ~&stim;
      endcase
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Monitor: compares o_stim every busy cycle and the results when o_done rises.
   int  neg_cnt;
   int  t0;
   bit  busy_prev;
   bit  done_prev;
   initial begin
      neg_cnt   = 0;
      t0        = 0;
      busy_prev = 1'b0;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         neg_cnt++;
         if (busy && !busy_prev) t0 = neg_cnt;
         if (mon_en && !rst) begin
            if (busy) begin
               if (exp_stim_q.size() == 0) check("stim_unexpected", 1, 0);
               else check("stim_seq", int'(stim), exp_stim_q.pop_front());
            end
            if (done && !done_prev) begin
               if (exp_res_q.size() == 0) check("done_unexpected", 1, 0);
               else begin
                  res_t r;
                  r = exp_res_q.pop_front();
                  check("fail_cnt",   int'(fail_cnt),   r.fail);
                  check("first_fail", int'(first_fail), r.first);
                  check("pass",       int'(pass),       r.pass);
                  check("done_lat",   neg_cnt - t0,     r.lat);
               end
            end
         end
         busy_prev = busy;
         done_prev = done;
      end
   end

   task automatic wait_done();
      int n;
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done) check("done_timeout", 0, 1);
      @(negedge clk);
   endtask

   // One full run; optional i_start pulse at cycle 3 while busy.
   task automatic run(input int mode, input int e_fail, input int e_first, input bit pulse_mid);
      res_t r;
      resp_mode = mode;
      for (int v = 0; v < 4; v++) begin
         exp_stim_q.push_back(v);
         exp_stim_q.push_back(v);
      end
      r.fail  = e_fail;
      r.first = e_first;
      r.pass  = (e_fail == 0) ? 1 : 0;
      r.lat   = 8;
      exp_res_q.push_back(r);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy",  int'(busy),       1);
      check("start_clear", int'(fail_cnt),   0);
      check("start_first", int'(first_fail), 0);
      if (pulse_mid) begin
         @(negedge clk);
         @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_done();
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      mon_en    = 1'b1;
      resp_mode = 0;
      rst       = 1'b1;
      start     = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_stim", int'(stim),       0);
      check("rst_busy", int'(busy),       0);
      check("rst_done", int'(done),       0);
      check("rst_pass", int'(pass),       0);
      check("rst_fail", int'(fail_cnt),   0);
      check("rst_first", int'(first_fail), 0);
      rst = 1'b0;
      @(negedge clk);

      run(0, 0, 0, 1'b0);    // AND: pass
      run(1, 1, 3, 1'b0);    // tied 0
      run(2, 2, 1, 1'b0);    // OR
      run(3, 4, 0, 1'b0);    // NAND: every vector fails
      run(1, 1, 3, 1'b1);    // mid-run start ignored
      run(1, 1, 3, 1'b0);    // restart from DONE clears and repeats
      check("done_hold_pass", int'(pass), 0);

      // Reset mid-run at o_stim == 2.
      mon_en    = 1'b0;
      resp_mode = 3;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      begin
         int n;
         n = 0;
         while (stim != 2'd2 && n < 20) begin
            @(negedge clk);
            n++;
         end
         check("reach_vec2", int'(stim), 2);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_stim",  int'(stim),       0);
      check("mid_rst_busy",  int'(busy),       0);
      check("mid_rst_done",  int'(done),       0);
      check("mid_rst_fail",  int'(fail_cnt),   0);
      check("mid_rst_first", int'(first_fail), 0);
      @(negedge clk);
      check("mid_rst_idle", int'(busy | done), 0);
      mon_en = 1'b1;
      run(0, 0, 0, 1'b0);

      check("stim_q_empty", exp_stim_q.size(), 0);
      check("res_q_empty",  exp_res_q.size(),  0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
